// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared types and constants for the MIPS instruction encoder.
//   mnem_e      - 4-bit mnemonic index on the encoder's input bus
//   OP_*/FN_*   - primary opcode and function-field constants
//   enc_state_e - output-register FSM state
//   enc_r/enc_i - field packers for R-type and I-type words
// Optional feature: INSTR_ENC_LI_EN (enables the two-word li pseudo-op).
package instr_enc_pkg;

  typedef enum logic [3:0] {
    MnAddu = 4'd0,
    MnSubu = 4'd1,
    MnXor  = 4'd2,
    MnNor  = 4'd3,
    MnJr   = 4'd4,
    MnJalr = 4'd5,
    MnClo  = 4'd6,
    MnClz  = 4'd7,
    MnOri  = 4'd8,
    MnLw   = 4'd9,
    MnSw   = 4'd10,
    MnBeq  = 4'd11,
    MnLui  = 4'd12,
    MnJ    = 4'd13,
    MnJal  = 4'd14,
    MnLi   = 4'd15
  } mnem_e;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_CLO  = 6'h21;
  localparam logic [5:0] FN_CLZ  = 6'h20;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFull = 2'd1,
    StLi2  = 2'd2
  } enc_state_e;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_enc_field.sv
// instr_enc_field: combinational mnemonic + fields -> 32-bit machine word.
// Ports:
//   i_mnem          mnemonic index (see mnem_e)
//   i_rs/i_rt/i_rd  register fields
//   i_imm           immediate / jump target / li constant
//   o_word          encoded (first) word
//   o_err           unsupported mnemonic; o_word is zero in that case
//   o_is_li         request expands to two words
//   o_word2         second li word (ori rt, rt, imm[15:0])
// Optional feature: INSTR_ENC_LI_EN (mnemonic 15 encodes as li).
module instr_enc_field
  import instr_enc_pkg::*;
(
  input  logic [3:0]  i_mnem,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err,
  output logic        o_is_li,
  output logic [31:0] o_word2
);

  mnem_e w_mnem;
  assign w_mnem = mnem_e'(i_mnem);

  always_comb begin
    o_word  = '0;
    o_err   = 1'b0;
    o_is_li = 1'b0;
    o_word2 = enc_i(OP_ORI, i_rt, i_rt, i_imm[15:0]);
    case (w_mnem)
      MnAddu: o_word = enc_r(OP_SPECIAL, i_rs, i_rt, i_rd, FN_ADDU);
      MnSubu: o_word = enc_r(OP_SPECIAL, i_rs, i_rt, i_rd, FN_SUBU);
      MnXor:  o_word = enc_r(OP_SPECIAL, i_rs, i_rt, i_rd, FN_XOR);
      MnNor:  o_word = enc_r(OP_SPECIAL, i_rs, i_rt, i_rd, FN_NOR);
      MnJr:   o_word = enc_r(OP_SPECIAL, i_rs, 5'd0, 5'd0, FN_JR);
      MnJalr: o_word = enc_r(OP_SPECIAL, i_rs, 5'd0, i_rd, FN_JALR);
      // SPECIAL2 count ops carry rd in the rt slot as well.
      MnClo:  o_word = enc_r(OP_SPECIAL2, i_rs, i_rd, i_rd, FN_CLO);
      MnClz:  o_word = enc_r(OP_SPECIAL2, i_rs, i_rd, i_rd, FN_CLZ);
      MnOri:  o_word = enc_i(OP_ORI, i_rs, i_rt, i_imm[15:0]);
      MnLw:   o_word = enc_i(OP_LW, i_rs, i_rt, i_imm[15:0]);
      MnSw:   o_word = enc_i(OP_SW, i_rs, i_rt, i_imm[15:0]);
      MnBeq:  o_word = enc_i(OP_BEQ, i_rs, i_rt, i_imm[15:0]);
      MnLui:  o_word = enc_i(OP_LUI, 5'd0, i_rt, i_imm[15:0]);
      MnJ:    o_word = {OP_J, i_imm[25:0]};
      MnJal:  o_word = {OP_JAL, i_imm[25:0]};
`ifdef INSTR_ENC_LI_EN
      MnLi: begin
        o_word  = enc_i(OP_LUI, 5'd0, i_rt, i_imm[31:16]);
        o_is_li = 1'b1;
      end
`else
      MnLi:   o_err = 1'b1;
`endif
      default: o_err = 1'b1;
    endcase
  end

`ifndef INSTR_ENC_LI_EN
  // Only li consumes imm[31:26].
  logic w_unused_imm;
  assign w_unused_imm = ^i_imm[31:26];
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential MIPS instruction encoder for the boot/test loader.
// Accepts one symbolic instruction per handshake and emits the machine word with its
// instruction-memory byte address.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   restart           synchronous: drop pending word, reload address to BASE_ADDR
//   in_valid/in_ready request handshake; in_mnem, in_rs, in_rt, in_rd, in_imm fields
//   out_valid/out_ready word handshake; out_word, out_addr, out_err (registered)
// Parameter: BASE_ADDR, byte address of the first emitted word.
// Optional feature: INSTR_ENC_LI_EN (li pseudo-op, LI2 state).
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        out_err
);

  enc_state_e  r_state;
  logic [31:0] r_word;
  logic [31:0] r_addr;
  logic        r_err;

  logic [31:0] w_word;
  logic [31:0] w_word2;
  logic        w_err;
  logic        w_is_li;
  logic        w_in_fire;
  logic        w_out_fire;
  enc_state_e  w_load_state;

  instr_enc_field u_field (
    .i_mnem  (in_mnem),
    .i_rs    (in_rs),
    .i_rt    (in_rt),
    .i_rd    (in_rd),
    .i_imm   (in_imm),
    .o_word  (w_word),
    .o_err   (w_err),
    .o_is_li (w_is_li),
    .o_word2 (w_word2)
  );

`ifdef INSTR_ENC_LI_EN
  logic [31:0] r_pend;
  assign w_load_state = w_is_li ? StLi2 : StFull;
`else
  assign w_load_state = StFull;
  logic w_unused_li;
  assign w_unused_li = w_is_li ^ (^w_word2);
`endif

  // A new request fits when the register is empty or is being drained this cycle;
  // restart always wins over acceptance.
  always_comb begin
    in_ready = 1'b0;
    if (!restart) begin
      case (r_state)
        StIdle:  in_ready = 1'b1;
        StFull:  in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign out_valid  = (r_state != StIdle);
  assign out_word   = r_word;
  assign out_addr   = r_addr;
  assign out_err    = r_err;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready & ~restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_err   <= 1'b0;
      r_addr  <= BASE_ADDR;
`ifdef INSTR_ENC_LI_EN
      r_pend  <= '0;
`endif
    end else if (restart) begin
      r_state <= StIdle;
      r_addr  <= BASE_ADDR;
    end else begin
      if (w_out_fire) begin
        r_addr <= r_addr + 32'd4;
      end
      // Acceptance only happens in IDLE or in FULL while draining, so loading here
      // also covers the back-to-back case.
      if (w_in_fire) begin
        r_word  <= w_word;
        r_err   <= w_err;
        r_state <= w_load_state;
`ifdef INSTR_ENC_LI_EN
        r_pend  <= w_word2;
`endif
      end else if (w_out_fire) begin
`ifdef INSTR_ENC_LI_EN
        if (r_state == StLi2) begin
          r_word  <= r_pend;
          r_err   <= 1'b0;
          r_state <= StFull;
        end else begin
          r_state <= StIdle;
        end
`else
        r_state <= StIdle;
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a behavioural encoding model. Honours INSTR_ENC_LI_EN.
module tb_instr_encoder;

  localparam logic [31:0] Base = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_mnem = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        out_err;

  instr_encoder #(.BASE_ADDR(Base)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mnem   (in_mnem),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] model_addr = Base;
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;

`ifdef INSTR_ENC_LI_EN
  localparam bit LiEn = 1'b1;
`else
  localparam bit LiEn = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: builds words by shifting fields into their bit positions.
  function automatic void ref_model(input int m, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [31:0] imm,
                                    output int n, output logic [31:0] w0,
                                    output logic [31:0] w1, output logic err);
    logic [31:0] s, t, d, lo, op, fn;
    s = {27'd0, rs};
    t = {27'd0, rt};
    d = {27'd0, rd};
    lo = imm & 32'h0000_FFFF;
    n = 1; w0 = 0; w1 = 0; err = 0; op = 0; fn = 0;
    case (m)
      0, 1, 2, 3: begin
        fn = (m == 0) ? 32'h21 : (m == 1) ? 32'h23 : (m == 2) ? 32'h26 : 32'h27;
        w0 = (s << 21) | (t << 16) | (d << 11) | fn;
      end
      4: w0 = (s << 21) | 32'h08;
      5: w0 = (s << 21) | (d << 11) | 32'h09;
      6, 7: w0 = (32'h1C << 26) | (s << 21) | (d << 16) | (d << 11) |
                 ((m == 6) ? 32'h21 : 32'h20);
      8, 9, 10, 11: begin
        op = (m == 8) ? 32'h0D : (m == 9) ? 32'h23 : (m == 10) ? 32'h2B : 32'h04;
        w0 = (op << 26) | (s << 21) | (t << 16) | lo;
      end
      12: w0 = (32'h0F << 26) | (t << 16) | lo;
      13: w0 = (32'h02 << 26) | (imm & 32'h03FF_FFFF);
      14: w0 = (32'h03 << 26) | (imm & 32'h03FF_FFFF);
      default: begin
        if (LiEn) begin
          n = 2;
          w0 = (32'h0F << 26) | (t << 16) | (imm >> 16);
          w1 = (32'h0D << 26) | (t << 21) | (t << 16) | lo;
        end else begin
          err = 1;
        end
      end
    endcase
  endfunction

  task automatic push(input logic [31:0] w, input logic err);
    exp_t e;
    e.word = w;
    e.addr = model_addr;
    e.err  = err;
    sb.push_back(e);
    model_addr += 32'd4;
  endtask

  // Entered just after a falling edge; returns just after a falling edge.
  task automatic send(input int m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm, input int n,
                      input logic [31:0] w0, input logic [31:0] w1, input logic err);
    bit acc = 1'b0;
    int waited = 0;
    in_valid = 1'b1;
    in_mnem  = m[3:0];
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    while (!acc && waited < 200) begin
      #4;
      if (in_ready) begin
        acc = 1'b1;
        push(w0, err);
        if (n == 2) push(w1, 1'b0);
      end
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept: got no handshake expected in_ready within 200 cycles");
    end
  endtask

  task automatic send_model(input int m, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] imm);
    int n;
    logic [31:0] w0, w1;
    logic err;
    ref_model(m, rs, rt, rd, imm, n, w0, w1, err);
    send(m, rs, rt, rd, imm, n, w0, w1, err);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every output handshake and checks that a stalled
  // word holds still.
  exp_t        mon_e;
  bit          hold = 1'b0;
  logic [31:0] hold_word, hold_addr;
  logic        hold_err;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!mon_en || !rst_n || restart) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_word", out_word, hold_word);
        check("stall_addr", out_addr, hold_addr);
        check("stall_err", out_err, hold_err);
      end
      if (out_valid && out_ready) begin
        hold = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h @ %h expected no word", out_word, out_addr);
        end else begin
          mon_e = sb.pop_front();
          check("out_word", out_word, mon_e.word);
          check("out_addr", out_addr, mon_e.addr);
          check("out_err", out_err, mon_e.err);
        end
      end else if (out_valid) begin
        hold = 1'b1;
        hold_word = out_word;
        hold_addr = out_addr;
        hold_err  = out_err;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #4;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_addr", out_addr, Base);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    mon_en = 1'b1;

    // addu after reset
    out_ready = 1'b1;
    send(0, 5'd1, 5'd2, 5'd3, 32'd0, 1, 32'h0022_1821, 0, 1'b0);
    drain();

    // back-to-back ori / lw
    send(8, 5'd0, 5'd8, 5'd0, 32'h0000_1234, 1, 32'h3408_1234, 0, 1'b0);
    send(9, 5'd29, 5'd9, 5'd0, 32'd4, 1, 32'h8FA9_0004, 0, 1'b0);
    drain();

    // li: in_ready drops while the ori half is pending
    if (LiEn) begin
      send(15, 5'd0, 5'd4, 5'd0, 32'hDEAD_BEEF, 2, 32'h3C04_DEAD, 32'h3484_BEEF, 1'b0);
      #4;
      check("li2_in_ready", in_ready, 0);
      @(negedge clk);
    end else begin
      send(15, 5'd0, 5'd4, 5'd0, 32'hDEAD_BEEF, 1, 32'h0000_0000, 0, 1'b1);
    end
    drain();

    // clz stalled for three cycles
    out_ready = 1'b0;
    send(7, 5'd6, 5'd0, 5'd5, 32'd0, 1, 32'h70C5_2820, 0, 1'b0);
    repeat (3) begin
      #4;
      check("clz_hold_valid", out_valid, 1);
      check("clz_hold_word", out_word, 32'h70C5_2820);
      check("clz_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();

    // j, then restart with a stalled word and a pending request
    send(13, 5'd0, 5'd0, 5'd0, 32'h0000_0C00, 1, 32'h0800_0C00, 0, 1'b0);
    drain();
    out_ready = 1'b0;
    send(2, 5'd7, 5'd8, 5'd9, 32'd0, 1, 32'h00E8_4826, 0, 1'b0);
    restart  = 1'b1;
    in_valid = 1'b1;
    in_mnem  = 4'd0;
    #4;
    check("restart_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("restart_out_valid", out_valid, 0);
    sb.delete();
    model_addr = Base;
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(1, 5'd4, 5'd5, 5'd6, 32'd0, 1, 32'h0085_3023, 0, 1'b0);
    drain();

    // async reset while the li second half (or a plain word) is pending
    out_ready = 1'b0;
    send_model(15, 5'd0, 5'd4, 5'd0, 32'hDEAD_BEEF);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_word", out_word, 0);
    check("arst_out_err", out_err, 0);
    check("arst_out_addr", out_addr, Base);
    check("arst_in_ready", in_ready, 1);
    sb.delete();
    model_addr = Base;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    mon_en = 1'b1;
    repeat (4) begin
      #4;
      check("arst_no_ori", out_valid, 0);
      @(negedge clk);
    end

    // randomized traffic against the model
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_model(int'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder: the inverse of the core's instruction decoder. Accepts one symbolic instruction per handshake (mnemonic index plus register/immediate fields) and emits the 32-bit machine word with its instruction-memory byte address. Intended for the boot/test loader that fills instruction memory. Supports the same 15-instruction subset the core decodes, plus an optional `li` pseudo-op that expands to two words.

## Interface
- `BASE_ADDR`, default `32'h0000_3000`: byte address of the first emitted word.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous; drops any pending word and reloads the address to `BASE_ADDR`.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `in_mnem`  in  4  0 addu, 1 subu, 2 xor, 3 nor, 4 jr, 5 jalr, 6 clo, 7 clz, 8 ori, 9 lw, 10 sw, 11 beq, 12 lui, 13 j, 14 jal, 15 li.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  32  field use depends on the instruction: [15:0] imm16; [25:0] jump target; all 32 bits for `li`.
- `out_valid`  out  1  word valid.
- `out_ready`  in  1  sink accepts the word.
- `out_word`  out  32  encoded instruction.
- `out_addr`  out  32  byte address of `out_word`.
- `out_err`  out  1  qualifies `out_word`; high marks an unsupported mnemonic.

## Operation
- R-type: {6'h00, rs, rt, rd, 5'b0, func}.
  - funcs: addu 0x21, subu 0x23, xor 0x26, nor 0x27.
  - jr: {0, rs, 15'b0, 0x08}.
  - jalr: {0, rs, 5'b0, rd, 5'b0, 0x09}.
- SPECIAL2 (op 0x1C): {0x1C, rs, rd, rd, 5'b0, func}, with rt forced equal to rd. Funcs: clo 0x21, clz 0x20.
- I-type: {op, rs, rt, imm[15:0]}.
  - ops: ori 0x0D, lw 0x23, sw 0x2B, beq 0x04.
  - lui: {0x0F, 5'b0, rt, imm[15:0]}.
- J-type: {op, imm[25:0]}. Ops: j 0x02, jal 0x03.
- li (with macro): emits two words in order.
  - First `lui rt, imm[31:16]`.
  - Then `ori rt, rt, imm[15:0]`.
  - Both words are always emitted, even when either half is zero.
- FSM states:
  - IDLE: output register empty.
  - FULL: output register holds a word.
  - LI2: output holds the lui word; the ori word is pending.
- Transitions:
  - IDLE + accept: go to FULL, or to LI2 for li.
  - FULL + out handshake with no accept: go to IDLE.
  - FULL + out handshake + accept in the same cycle: go to FULL or LI2, back-to-back.
  - LI2 + out handshake: load the ori word, go to FULL.
- `in_ready`:
  - 1 in IDLE.
  - In FULL, equal to `out_ready`.
  - 0 in LI2.
- Address counter:
  - Starts at `BASE_ADDR`.
  - Adds 4 on every output handshake.
  - Wraps modulo 2^32; no flag on wrap.
- `restart`:
  - Forces IDLE, clears `out_valid`, reloads the address.
  - Overrides a same-cycle input or output handshake; the input is not accepted (`in_ready` is 0 that cycle).

## Timing
- Reset values: `out_valid` 0, `out_word` 0, `out_err` 0, `out_addr` = `BASE_ADDR`, state IDLE, `in_ready` 1.
- Latency: `out_valid` rises in the cycle after input acceptance.
- Throughput: one word per cycle under continuous `out_ready`. li occupies two output cycles.
- `out_word`, `out_addr` and `out_err` are registered and stay stable while `out_valid` is high and `out_ready` is low.
- Reset asserted mid-li: the pending ori is discarded.

## Configuration
- `INSTR_ENC_LI_EN` defined: mnemonic 15 expands as `li`; LI2 state exists.
- `INSTR_ENC_LI_EN` undefined:
  - Mnemonic 15 emits one word 32'h0000_0000 with `out_err`=1, and the address still advances.
  - LI2 is not synthesized.

## Structure
- Package `instr_enc_pkg` holds:
  - the mnemonic enum;
  - opcode/func constants (OP_SPECIAL, OP_SPECIAL2, OP_ORI, …, FN_ADDU, …);
  - the FSM state typedef.
- Sub-module `instr_enc_field`: purely combinational mnemonic+fields → word/err. The top holds the FSM, output register and address counter.

## Test plan
- After reset, addu rd=3 rs=1 rt=2 → `out_word` 0x00221821 @ `out_addr` 0x3000, `out_err`=0.
- Back-to-back ori rt=8 rs=0 imm=0x1234, then lw rt=9 rs=29 imm=4, with `out_ready`=1 → 0x34081234 @ 0x3000, then 0x8FA90004 @ 0x3004 on consecutive cycles.
- li rt=4 imm=0xDEADBEEF → 0x3C04DEAD then 0x3484BEEF; `in_ready`=0 for the LI2 cycle. Without the macro → 0x00000000 with `out_err`=1.
- clz rd=5 rs=6 held with `out_ready`=0 for 3 cycles → 0x70C52820 stable, `in_ready`=0; word released on `out_ready`.
- j imm=0x0000C00 → 0x08000C00. Then `restart` asserted with `in_valid` high → `out_valid`=0, input not accepted, next word addressed at 0x3000.
- `rst_n` low during LI2 → all outputs at reset values immediately (asynchronously); no ori word emitted afterwards.
